// File: rtl/window_gen_5x5.sv
// window_gen_5x5: streaming 5x5 neighbourhood generator.
// Four cascaded line stores feed a 5x5 shift window; one window per interior pixel.
module window_gen_5x5 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DW-1:0]              in_pix,
  output logic                       win_valid,
  output logic [25*DW-1:0]           win_pix,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_FOUR = XW'(4);
  localparam logic [YW-1:0] Y_FOUR = YW'(4);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  logic [XW-1:0]    x_q, x_d, cx;
  logic [YW-1:0]    y_q, y_d, cy;
  logic [25*DW-1:0] win_q, win_d;
  logic             valid_q, valid_d;
  logic [XW-1:0]    wx_q, wx_d;
  logic [YW-1:0]    wy_q, wy_d;
  logic [DW-1:0]    col [5];

  // Line store k holds the row k+1 above the current one, addressed by column.
  logic [DW-1:0]    lb_mem [4][IMG_W];

  // Coordinate of the pixel being accepted (SOF forces origin) and next counters.
  always_comb begin
    cx  = in_sof ? '0 : x_q;
    cy  = in_sof ? '0 : y_q;
    x_d = x_q;
    y_d = y_q;
    if (in_valid) begin
      if (cx == X_MAX) begin
        x_d = '0;
        y_d = (cy == Y_MAX) ? '0 : cy + 1'b1;
      end else begin
        x_d = cx + 1'b1;
        y_d = cy;
      end
    end
  end

  // New window column: current pixel at bottom, oldest line at top.
  always_comb begin
    col[4] = in_pix;
    for (int k = 0; k < 4; k++) begin
      col[3-k] = lb_mem[k][cx];
    end
  end

  // Shift window left on each accepted pixel; flag interior centres.
  always_comb begin
    win_d   = win_q;
    valid_d = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    if (in_valid) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[DW*(5*r+c) +: DW] = win_q[DW*(5*r+c+1) +: DW];
        end
        win_d[DW*(5*r+4) +: DW] = col[r];
      end
      valid_d = (cx >= X_FOUR) && (cy >= Y_FOUR);
      if (valid_d) begin
        wx_d = cx - X_TWO;
        wy_d = cy - Y_TWO;
      end
    end
  end

  // Counters and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end

  // Cascade line stores: each passes its old value at this column down one line.
  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      lb_mem[0][cx] <= in_pix;
      for (int k = 1; k < 4; k++) begin
        lb_mem[k][cx] <= lb_mem[k-1][cx];
      end
    end
  end

  assign win_valid = valid_q;
  assign win_pix   = win_q;
  assign win_x     = wx_q;
  assign win_y     = wy_q;

endmodule

// File: doc/window_gen_5x5.md
Name: window_gen_5x5

Overview:
- Streaming 5x5 neighbourhood generator for the 5x5 median filter path.
- Accepts one raster-order pixel per valid cycle.
- Buffers four previous image lines and emits the full 5x5 window around each interior pixel.
- Drives the pixel-tap inputs of the downstream rank-selection stage (it is the producer side of that window interface).

Parameters:
- IMG_W, 640, active pixels per line (>=5)
- IMG_H, 480, lines per frame (>=5)
- DW, 8, pixel width in bits

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_pix is valid this cycle; no backpressure, every valid pixel is accepted
- in_sof  in  1  qualified by in_valid: this pixel is (x=0,y=0) of a new frame
- in_pix  in  DW  input pixel, raster order
- win_valid  out  1  win_pix/win_x/win_y valid this cycle (one-cycle pulse per window)
- win_pix  out  25*DW  window; tap (r,c) at bits [DW*(5r+c) +: DW]; r=0 oldest line, c=0 oldest column; centre tap = index 12
- win_x  out  clog2(IMG_W)  column of window centre
- win_y  out  clog2(IMG_H)  row of window centre

Behaviour:
- Reset: rst_n sampled on clk edge only. On reset all of the following clear to 0: win_valid, win_pix, win_x, win_y, column counter x, row counter y, window registers. Line-buffer contents need not clear. Reset mid-frame abandons the frame; the next accepted pixel is treated as (0,0) whether or not in_sof is set.
- Counters: x advances on each accepted pixel. At x==IMG_W-1, x wraps to 0 and y increments. At y==IMG_H-1 with x==IMG_W-1, both wrap to 0.
- in_sof with in_valid forces the accepted pixel to coordinate (0,0), overriding the counters, and counting continues from there. in_sof without in_valid is ignored.
- Line buffers: four depth-IMG_W delay lines, cascaded. Line k outputs the pixel from k+1 lines above the current column. Written only on accepted pixels. Implement as a RAM with column address = x, or as shift registers; behaviour is identical.
- Window: on each accepted pixel, shift the 5x5 register left one column. The new column c=4 is loaded as follows:
  - r=4: in_pix
  - r=3..0: line-buffer outputs for 1..4 lines above
- No shift when in_valid=0; the window holds.
- Output timing: win_valid is registered and asserts the cycle after accepting pixel (x,y) iff x>=4 and y>=4. At that cycle:
  - win_pix holds rows y-4..y and columns x-4..x.
  - win_x = x-2, win_y = y-2.
- Latency is 1 clk from the accepted pixel to its window.
- Borders: no padding and no output for border centres. Each frame yields exactly (IMG_W-4)*(IMG_H-4) windows.
- Line wrap: windows never span lines. Column gating (x>=4) suppresses the four cycles after the wrap while stale columns flush.
- Stalls: in_valid gaps of any length between pixels, including mid-line and at line and frame ends, do not change the output sequence. win_valid stays low during gaps.
- Frame back-to-back: the first pixel of the next frame may directly follow the last pixel of the previous one. The final window of frame N is still emitted, and row gating (y>=4) blocks stale data in frame N+1.
- No overflow condition exists: there is one output per input at most, with no buffering beyond the line stores.

Test Plan:
- Nominal frame: IMG_W=8, IMG_H=6, DW=8, in_pix=8y+x, in_valid continuous, in_sof on the first pixel.
  - First win_valid occurs 1 clk after pixel 36 (x=4,y=4), with win_x=2, win_y=2, tap0=0, tap12=18, tap24=36.
  - Exactly 8 win_valid pulses; the last has centre 29 and tap24=47.
- Random stalls: same frame, in_valid toggled pseudo-randomly (~40% idle).
  - Window contents and coordinate sequence are identical to the nominal run.
  - win_valid is never high in the cycle after an idle cycle.
- Line-wrap gating: nominal frame. win_valid stays low for accepted pixels (0..3, y>=4), e.g. pixel 40.
  - No window mixes columns from two lines.
- SOF resync: assert in_sof on the 20th pixel of a frame, then stream a full frame.
  - Counters restart, giving 8 valid windows with correct values relative to the new origin.
  - No window is emitted before the new y reaches 4.
- Reset mid-frame: drop rst_n for one clk after pixel 38.
  - All outputs are 0 next cycle.
  - The following 48 pixels, sent without in_sof, produce the nominal 8 windows.
- Back-to-back frames: two nominal frames with no idle cycle between them and in_sof on each frame start.
  - 16 windows total; the second frame's first window appears 1 clk after its pixel 36, with tap12=18.
